inv_chi_step_seq: RTL and testbench

- Iterative inverse of the Keccak χ step: given a state B, produces the unique A with χ(A) = B, where χ(A)[x,y] = A[x,y] XOR ((NOT A[x+1,y]) AND A[x+2,y]) and x indices are mod 5.
- Computes PLANES_PER_CYCLE planes (fixed y) per clock behind a valid/ready handshake on both sides.
- Sits in the keccak_pkg datapath as the decode-direction counterpart of the χ layer. Used for round-inversion checks and for the verification models' reverse permutation.

---
 rtl/inv_chi_step_seq.sv | 135 +++++++++++++
 tb/tb_inv_chi_step_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_chi_step_seq.sv
// Iterative inverse of the Keccak chi step: recovers A from B = chi(A),
// PLANES_PER_CYCLE y-planes per BUSY cycle, valid/ready on both sides.
module inv_chi_step_seq #(
  parameter  int PLANES_PER_CYCLE = 1,
  localparam int ROW_SIZE         = 5,
  localparam int COL_SIZE         = 5,
  localparam int LANE_SIZE        = 64
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         valid_i,
  output logic                                         ready_o,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
  output logic                                         valid_o,
  input  logic                                         ready_i,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_o
);

  localparam int P = PLANES_PER_CYCLE;

  if (!(P == 1 || P == 5)) begin : g_bad_param
    $error("inv_chi_step_seq: PLANES_PER_CYCLE must be 1 or 5");
  end

  localparam logic [2:0] P3       = 3'(P);
  localparam logic [2:0] LAST_CNT = 3'(COL_SIZE / P - 1);

  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;

  function automatic logic [4:0] chi_row(input logic [4:0] a);
    logic [4:0] b;
    for (int x = 0; x < 5; x++) begin
      b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
    end
    return b;
  endfunction

  // Inverse map built at elaboration by scattering the forward chi map.
  function automatic logic [31:0][4:0] build_inv_table();
    logic [31:0][4:0] tbl;
    logic [4:0]       a;
    tbl = '0;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      tbl[chi_row(a)] = a;
    end
    return tbl;
  endfunction

  localparam logic [31:0][4:0] INV_TBL = build_inv_table();

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  state_t     in_q, in_d;
  state_t     out_q, out_d;

  logic [P-1:0][2:0]                          plane_idx;
  logic [P-1:0][LANE_SIZE-1:0][ROW_SIZE-1:0]  sel_rows;
  logic [P-1:0][LANE_SIZE-1:0][ROW_SIZE-1:0]  inv_rows;

  for (genvar gi = 0; gi < P; gi++) begin : g_plane
    assign plane_idx[gi] = cnt_q * P3 + 3'(gi);
    for (genvar gz = 0; gz < LANE_SIZE; gz++) begin : g_slice
      for (genvar gx = 0; gx < ROW_SIZE; gx++) begin : g_row_bit
        assign sel_rows[gi][gz][gx] = in_q[gx][plane_idx[gi]][gz];
      end
      assign inv_rows[gi][gz] = INV_TBL[sel_rows[gi][gz]];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    out_d   = out_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          in_d    = state_array_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Planes not addressed this cycle keep their previous contents.
        for (int g = 0; g < P; g++) begin
          for (int z = 0; z < LANE_SIZE; z++) begin
            for (int x = 0; x < ROW_SIZE; x++) begin
              out_d[x][plane_idx[g]][z] = inv_rows[g][z][x];
            end
          end
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  assign state_array_o = out_q;

endmodule

// File: tb/tb_inv_chi_step_seq.sv
// Directed and round-trip checks of inv_chi_step_seq for both plane rates
// (P=1 and P=5 instances share clock and reset).
module tb_inv_chi_step_seq;

  typedef logic [4:0][4:0][63:0] state_t;

  typedef struct {
    string  name;
    state_t b;
    state_t a;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;

  logic   v_i1 = 1'b0, r_i1 = 1'b0, r_o1, v_o1;
  logic   v_i5 = 1'b0, r_i5 = 1'b0, r_o5, v_o5;
  state_t din1 = '0, din5 = '0, dout1, dout5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inv_chi_step_seq #(.PLANES_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_i1), .ready_o(r_o1),
    .state_array_i(din1), .valid_o(v_o1), .ready_i(r_i1), .state_array_o(dout1)
  );

  inv_chi_step_seq #(.PLANES_PER_CYCLE(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_i5), .ready_o(r_o5),
    .state_array_i(din5), .valid_o(v_o5), .ready_i(r_i5), .state_array_o(dout5)
  );

  function automatic state_t chi_model(input state_t a);
    state_t b;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[x][y] = a[x][y] ^ (~a[(x + 1) % 5][y] & a[(x + 2) % 5][y]);
    return b;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_state(input string name, input state_t got, input state_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          if (got[x][y] !== exp[x][y]) begin
            $display("FAIL %s lane[%0d][%0d] got=%h exp=%h", name, x, y, got[x][y], exp[x][y]);
            return;
          end
    end
  endtask

  function automatic logic dut_ready(input int p);
    return (p == 1) ? r_o1 : r_o5;
  endfunction

  function automatic logic dut_valid(input int p);
    return (p == 1) ? v_o1 : v_o5;
  endfunction

  task automatic set_in(input int p, input logic v, input state_t d);
    if (p == 1) begin v_i1 = v; din1 = d; end
    else        begin v_i5 = v; din5 = d; end
  endtask

  task automatic set_rdy(input int p, input logic r);
    if (p == 1) r_i1 = r; else r_i5 = r;
  endtask

  // Submit b, wait for the result, return it with latency, then drain.
  task automatic submit(input int p, input state_t b, output int lat);
    int n;
    n = 0;
    while (!dut_ready(p) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL ready_timeout p=%0d got=0 exp=1", p);
    end
    set_in(p, 1'b1, b);
    @(posedge clk); #1;
    set_in(p, 1'b0, b);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (dut_valid(p)) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL valid_timeout p=%0d got=0 exp=1", p);
    end
  endtask

  task automatic drain(input int p);
    set_rdy(p, 1'b1);
    @(posedge clk); #1;
    set_rdy(p, 1'b0);
    chk_int("ready_after_done", int'(dut_ready(p)), 1);
  endtask

  vec_t   vecs[4];
  state_t a_exp, got, held, b_in;
  int     lat;

  initial begin
    // Directed table; inverse of a one-hot row e_y is bits {y, y+1, y+3}.
    vecs[0].name = "known_01001";
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        vecs[0].b[x][y] = (x == 0 || x == 3) ? '1 : '0;
        vecs[0].a[x][y] = (x == 0) ? '1 : '0;
      end
    vecs[1].name = "all_zeros"; vecs[1].b = '0; vecs[1].a = '0;
    vecs[2].name = "all_ones";  vecs[2].b = '1; vecs[2].a = '1;
    vecs[3].name = "mixed_planes";
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        vecs[3].b[x][y] = (x == y) ? '1 : '0;
        vecs[3].a[x][y] = (x == y || x == (y + 1) % 5 || x == (y + 3) % 5) ? '1 : '0;
      end

    // Reset with valid_i high and garbage data: nothing is accepted.
    rst_n = 1'b0;
    set_in(1, 1'b1, '1);
    set_in(5, 1'b1, '1);
    repeat (2) @(posedge clk);
    #1;
    chk_int("rst_valid1", int'(v_o1), 0);
    chk_int("rst_valid5", int'(v_o5), 0);
    chk_state("rst_out1", dout1, '0);
    chk_state("rst_out5", dout5, '0);
    rst_n = 1'b1;
    set_in(1, 1'b0, '0);
    set_in(5, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk_int("rst_ready1", int'(r_o1), 1);
    chk_int("rst_ready5", int'(r_o5), 1);
    chk_int("rst_idle_valid1", int'(v_o1), 0);
    $display("txn reset done");

    for (int i = 0; i < 4; i++) begin
      for (int pp = 0; pp < 2; pp++) begin
        int p;
        p = (pp == 0) ? 1 : 5;
        submit(p, vecs[i].b, lat);
        got = (p == 1) ? dout1 : dout5;
        chk_state({vecs[i].name, "_data"}, got, vecs[i].a);
        chk_int({vecs[i].name, "_latency"}, lat, (p == 1) ? 5 : 1);
        drain(p);
        $display("txn vec=%s p=%0d lat=%0d", vecs[i].name, p, lat);
      end
    end

    // Backpressure in DONE with valid_i and data toggling.
    a_exp = rand_state();
    submit(1, chi_model(a_exp), lat);
    held = dout1;
    chk_state("bp_first", held, a_exp);
    for (int c = 0; c < 20; c++) begin
      set_in(1, c[0], rand_state());
      @(posedge clk); #1;
      chk_int("bp_valid", int'(v_o1), 1);
      chk_int("bp_ready", int'(r_o1), 0);
      chk_state("bp_hold", dout1, held);
    end
    set_in(1, 1'b0, '0);
    drain(1);
    a_exp = rand_state();
    submit(1, chi_model(a_exp), lat);
    chk_state("bp_next", dout1, a_exp);
    drain(1);
    $display("txn backpressure lat=%0d", lat);

    // Reset sampled at E3 of a P=1 operation.
    a_exp = rand_state();
    set_in(1, 1'b1, chi_model(a_exp));
    @(posedge clk); #1;
    set_in(1, 1'b0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_int("midrst_ready", int'(r_o1), 1);
    chk_state("midrst_out", dout1, '0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        if (v_o1) seen++;
      end
      chk_int("midrst_no_valid", seen, 0);
    end
    a_exp = rand_state();
    submit(1, chi_model(a_exp), lat);
    chk_state("midrst_next", dout1, a_exp);
    chk_int("midrst_next_lat", lat, 5);
    drain(1);
    $display("txn midreset lat=%0d", lat);

    // Round trip through the forward model for both rates.
    for (int pp = 0; pp < 2; pp++) begin
      int p;
      p = (pp == 0) ? 1 : 5;
      for (int t = 0; t < 1000; t++) begin
        a_exp = rand_state();
        b_in = chi_model(a_exp);
        submit(p, b_in, lat);
        got = (p == 1) ? dout1 : dout5;
        chk_state("roundtrip", got, a_exp);
        set_rdy(p, 1'b1);
        @(posedge clk); #1;
        set_rdy(p, 1'b0);
        $display("txn roundtrip p=%0d id=%0d lat=%0d", p, t, lat);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
